// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock,
// WIDTH cycles per divide, start/busy/done handshake toward the control unit.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | iterating, one quotient bit per cycle, busy=1
   // DONE  | single cycle, done=1, start may be accepted back-to-back
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] q_sr;
   logic [WIDTH-1:0] dvsr;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] q_nxt;

   // The partial remainder stays below the divisor, so WIDTH bits of storage
   // suffice; only the shifted value needs the extra bit for the trial.
   always_comb begin
      shifted = {rem, q_sr[WIDTH-1]};
      trial   = shifted - {1'b0, dvsr};
      rem_nxt = shifted[WIDTH-1:0];
      q_nxt   = {q_sr[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_nxt = trial[WIDTH-1:0];
         q_nxt   = {q_sr[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         q_sr        <= '0;
         dvsr        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor != '0) begin
                     dvsr        <= divisor;
                     rem         <= '0;
                     q_sr        <= dividend;
                     cnt         <= CW'(WIDTH - 1);
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state       <= RUN;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem  <= rem_nxt;
               q_sr <= q_nxt;
               if (cnt == '0) begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_nxt;
                  remainder <= rem_nxt;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (WIDTH=8): results, latency,
// busy length, divide-by-zero, handshake corner cases and async reset.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int errors = 0;
   int checks = 0;
   int lat;
   int nbusy;
   int done_seen;

   seq_divider #(.WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive a start pulse; returns at the sample point right after the
   // accepting edge (sample index 0).
   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Sample index j = edges after acceptance; returns with done seen (at
   // index lat), and the number of busy samples before it.
   task automatic wait_done(input int j0, input int nb0, output int lat_o, output int nbusy_o);
      int j;
      j = j0;
      nbusy_o = nb0;
      while (!done && j < 40) begin
         if (busy) nbusy_o++;
         @(negedge clk);
         j++;
      end
      lat_o = done ? j : -1;
   endtask

   task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int eq, input int er, input int edz, input int elat);
      int l, nb;
      start_op(a, b);
      wait_done(0, 0, l, nb);
      chk({tag, " latency"}, l, elat);
      chk({tag, " busy_cycles"}, nb, elat);
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      chk({tag, " div_by_zero"}, div_by_zero, edz);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset dbz", div_by_zero, 0);
      @(negedge clk); rst = 1'b0;

      run_check("200/7", 8'd200, 8'd7, 28, 4, 0, 8);
      @(negedge clk);
      chk("done one pulse", done, 0);
      chk("result held", quotient, 28);

      run_check("255/1", 8'd255, 8'd1, 255, 0, 0, 8);
      run_check("5/9", 8'd5, 8'd9, 0, 5, 0, 8);
      run_check("255/255", 8'd255, 8'd255, 1, 0, 0, 8);
      run_check("0/13", 8'd0, 8'd13, 0, 0, 0, 8);
      run_check("77/0", 8'd77, 8'd0, 255, 77, 1, 0);
      run_check("10/3", 8'd10, 8'd3, 3, 1, 0, 8);

      // Start during RUN is ignored; previous result stays visible meanwhile.
      start_op(8'd100, 8'd3);
      chk("run busy", busy, 1);
      @(negedge clk); @(negedge clk);
      chk("run keeps old q", quotient, 3);
      chk("run dbz clear", div_by_zero, 0);
      @(negedge clk); @(negedge clk);
      dividend = 8'd9; divisor = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(5, 5, lat, nbusy);
      chk("100/3 latency", lat, 8);
      chk("100/3 busy_cycles", nbusy, 8);
      chk("100/3 quotient", quotient, 33);
      chk("100/3 remainder", remainder, 1);

      // Back-to-back: start held in the done cycle.
      dividend = 8'd9; divisor = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b busy", busy, 1);
      chk("b2b done low", done, 0);
      wait_done(0, 0, lat, nbusy);
      chk("9/2 latency", lat, 8);
      chk("9/2 quotient", quotient, 4);
      chk("9/2 remainder", remainder, 1);

      // Async reset mid-RUN.
      start_op(8'd200, 8'd7);
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst quotient", quotient, 0);
      chk("rst remainder", remainder, 0);
      @(negedge clk); rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("rst no done", done_seen, 0);
      run_check("200/7 after rst", 8'd200, 8'd7, 28, 4, 0, 8);

      for (int i = 0; i < 1000; i++) begin
         int a, b, l, nb;
         a = int'($urandom_range(255, 0));
         b = int'($urandom_range(255, 1));
         start_op(8'(a), 8'(b));
         wait_done(0, 0, l, nb);
         if (l != 8 || quotient != 8'(a / b) || remainder != 8'(a % b)) begin
            chk($sformatf("rnd %0d/%0d latency", a, b), l, 8);
            chk($sformatf("rnd %0d/%0d quotient", a, b), quotient, a / b);
            chk($sformatf("rnd %0d/%0d remainder", a, b), remainder, a % b);
         end else begin
            checks += 3;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
